// File: rtl/flex_serializer.sv
// Buffers IN_WIDTH-bit words and emits them as OUT_WIDTH-bit segments with
// downstream backpressure, per-word segment count and a last-segment marker.
module flex_serializer #(
   parameter int IN_WIDTH  = 512,
   parameter int OUT_WIDTH = 32,
   parameter int DEPTH     = 2,
   parameter bit MSB_FIRST = 1'b0,
   localparam int NUM_SEG  = IN_WIDTH / OUT_WIDTH,
   localparam int SEG_W    = $clog2(NUM_SEG) + 1,
   localparam int LVL_W    = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 data_ready,
   output logic                 read_data,
   input  logic [IN_WIDTH-1:0]  data_in,
   input  logic [SEG_W-1:0]     seg_count,
   input  logic                 out_ready,
   output logic                 write_data,
   output logic [OUT_WIDTH-1:0] data_out,
   output logic                 data_last,
   output logic [LVL_W-1:0]     level
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

   function automatic logic [OUT_WIDTH-1:0] seg_of(input logic [IN_WIDTH-1:0] word,
                                                   input logic [SEG_W-1:0] idx);
      int pos;
      pos = MSB_FIRST ? (NUM_SEG - 1 - int'(idx)) : int'(idx);
      return word[pos*OUT_WIDTH +: OUT_WIDTH];
   endfunction

   function automatic logic [SEG_W-1:0] eff_count(input logic [SEG_W-1:0] cnt);
      return ((cnt == {SEG_W{1'b0}}) || (cnt > SEG_W'(NUM_SEG))) ? SEG_W'(NUM_SEG) : cnt;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   logic [IN_WIDTH-1:0]  mem_data_r [DEPTH];
   logic [SEG_W-1:0]     mem_cnt_r  [DEPTH];
   state_t               state_r, state_s;
   logic [PTR_W-1:0]     rd_ptr_r, rd_ptr_s, wr_ptr_r, wr_ptr_s;
   logic [LVL_W-1:0]     level_r, level_s;
   logic [SEG_W-1:0]     seg_idx_r, seg_idx_s;
   logic [OUT_WIDTH-1:0] data_out_r, data_out_s;
   logic                 data_last_r, data_last_s;
   logic                 read_data_r, read_data_s;
   logic                 accept_s, xfer_s, done_s;
   logic [IN_WIDTH-1:0]  head_word_s, next_word_s;
   logic [SEG_W-1:0]     head_cnt_s, next_cnt_s;

   assign accept_s    = data_ready && read_data_r;
   assign xfer_s      = (state_r == SEND) && out_ready;
   assign done_s      = xfer_s && data_last_r;
   assign head_word_s = mem_data_r[rd_ptr_r];
   assign head_cnt_s  = mem_cnt_r[rd_ptr_r];
   // With only the finishing word held, a same-cycle accept is forwarded straight from the input.
   assign next_word_s = (level_r > LVL_W'(1)) ? mem_data_r[ptr_inc(rd_ptr_r)] : data_in;
   assign next_cnt_s  = (level_r > LVL_W'(1)) ? mem_cnt_r[ptr_inc(rd_ptr_r)] : eff_count(seg_count);
   assign level_s     = level_r + LVL_W'(accept_s) - LVL_W'(done_s);
   assign wr_ptr_s    = accept_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
   assign read_data_s = (level_s < LVL_W'(DEPTH));

   assign read_data  = read_data_r;
   assign write_data = (state_r == SEND);
   assign data_out   = data_out_r;
   assign data_last  = data_last_r;
   assign level      = level_r;

   // Next-state and next-segment selection.
   always_comb begin
      state_s     = state_r;
      seg_idx_s   = seg_idx_r;
      data_out_s  = data_out_r;
      data_last_s = data_last_r;
      rd_ptr_s    = rd_ptr_r;
      case (state_r)
         IDLE: begin
            if (level_r != {LVL_W{1'b0}}) begin
               state_s     = SEND;
               seg_idx_s   = {SEG_W{1'b0}};
               data_out_s  = seg_of(head_word_s, {SEG_W{1'b0}});
               data_last_s = (head_cnt_s == SEG_W'(1));
            end else begin
               state_s = IDLE;
            end
         end
         SEND: begin
            if (done_s) begin
               rd_ptr_s  = ptr_inc(rd_ptr_r);
               seg_idx_s = {SEG_W{1'b0}};
               if ((level_r > LVL_W'(1)) || accept_s) begin
                  data_out_s  = seg_of(next_word_s, {SEG_W{1'b0}});
                  data_last_s = (next_cnt_s == SEG_W'(1));
               end else begin
                  state_s     = IDLE;
                  data_last_s = 1'b0;
               end
            end else if (xfer_s) begin
               seg_idx_s   = seg_idx_r + SEG_W'(1);
               data_out_s  = seg_of(head_word_s, seg_idx_s);
               data_last_s = (seg_idx_s == (head_cnt_s - SEG_W'(1)));
            end else begin
               state_s = SEND;
            end
         end
         default: begin
            state_s     = IDLE;
            data_last_s = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Pointers, occupancy and registered output segment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_r    <= {PTR_W{1'b0}};
         wr_ptr_r    <= {PTR_W{1'b0}};
         level_r     <= {LVL_W{1'b0}};
         seg_idx_r   <= {SEG_W{1'b0}};
         data_out_r  <= {OUT_WIDTH{1'b0}};
         data_last_r <= 1'b0;
         read_data_r <= 1'b1;
      end else begin
         rd_ptr_r    <= rd_ptr_s;
         wr_ptr_r    <= wr_ptr_s;
         level_r     <= level_s;
         seg_idx_r   <= seg_idx_s;
         data_out_r  <= data_out_s;
         data_last_r <= data_last_s;
         read_data_r <= read_data_s;
      end
   end

   // Word buffer storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_data_r[wr_ptr_r] <= data_in;
         mem_cnt_r[wr_ptr_r]  <= eff_count(seg_count);
      end
   end
endmodule

// File: doc/flex_serializer.md
Name: flex_serializer

Overview:
Parametrised successor to the fixed-ratio serializer. It accepts IN_WIDTH-bit words into a small internal buffer and emits them as OUT_WIDTH-bit segments. Additions over the fixed-ratio block: downstream backpressure, selectable segment order, per-word variable segment count, and a last-segment marker. It sits between a wide datapath and a narrow link or FIFO.

Parameters:
IN_WIDTH, 512, input word width; must be an integer multiple of OUT_WIDTH.
OUT_WIDTH, 32, output segment width.
DEPTH, 2, input buffer depth in words (>=1).
MSB_FIRST, 0, segment order: 0 = bits [OUT_WIDTH-1:0] first; 1 = top segment first.
Derived: NUM_SEG = IN_WIDTH/OUT_WIDTH (>=2); SEG_W = $clog2(NUM_SEG)+1; LVL_W = $clog2(DEPTH+1).

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
data_ready  input  1  upstream word valid
read_data  output  1  block can accept a word; a word is accepted on a cycle with data_ready && read_data
data_in  input  IN_WIDTH  input word
seg_count  input  SEG_W  number of segments to send for this word (0 = NUM_SEG); sampled with data_in
out_ready  input  1  downstream accepts a segment this cycle
write_data  output  1  data_out valid
data_out  output  OUT_WIDTH  current segment
data_last  output  1  current segment is the final one of its word
level  output  LVL_W  words held (buffered plus the word in progress)

Behaviour:
- Reset (reset low, asynchronous assert, synchronous release): write_data=0, data_last=0, data_out=0, level=0, read_data=1. Segment index=0. Buffer pointers=0. Buffered words are discarded, including reset asserted mid-word.
- read_data = (level < DEPTH), driven from registered state only. It has no combinational path from out_ready or data_ready.
- A pop in the same cycle does not make room for a push when level==DEPTH. read_data stays 0 that cycle.
- Accept: on accepted cycle, the word and its effective count are written to the buffer. Effective count = NUM_SEG if seg_count==0 or seg_count>NUM_SEG (clamp), else seg_count.
- level: +1 on accept, -1 when the last segment of a word transfers. Unchanged if both occur in the same cycle.
- Output is registered. A segment transfers on a cycle with write_data && out_ready.
- Latency: a word accepted into an empty block at edge N presents segment 0 with write_data=1 after edge N+1.
- Segment k of a word: MSB_FIRST=0 gives data_in[k*OUT_WIDTH +: OUT_WIDTH]; MSB_FIRST=1 gives data_in[(NUM_SEG-1-k)*OUT_WIDTH +: OUT_WIDTH].
- Advance: on transfer, the segment index increments. On a transfer of the segment with index count-1, data_last is 1, the index wraps to 0, and the word is popped.
- If another word is buffered, its segment 0 is presented on the next cycle. There is no bubble between words at out_ready=1.
- If no word is buffered, write_data drops to 0 and data_last drops to 0.
- Stall: while write_data=1 and out_ready=0, data_out, data_last and write_data hold their values.
- out_ready while write_data=0 has no effect.
- FSM: IDLE (no word, write_data=0) -> SEND when level>0. SEND -> SEND on word completion with level>1. SEND -> IDLE on word completion with level==1 and no simultaneous accept.
- An accept while in IDLE does not produce output until the next cycle.
- Throughput: one segment per cycle at out_ready=1. Upstream is never the bottleneck for DEPTH>=2 and count>=2.
- data_in and seg_count are ignored on cycles without accept.

Test Plan:
- Reset then one full word, defaults, seg k = k (k=0..15), out_ready=1 -> write_data high one cycle after accept. data_out is 0..15 on consecutive cycles. data_last only on 15. level returns 0.
- MSB_FIRST=1, same word -> data_out 15,14,...,0. data_last on 0.
- seg_count=3, then seg_count=0, then seg_count=20 -> 3 segments, then 16, then 16 (clamped). data_last on the 3rd, 19th and 35th transfers.
- data_ready held 1, out_ready held 1, 8 words -> 128 contiguous write_data cycles with no gap.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> data_out is stable during stalls and no segment is lost or duplicated. After 2 words level==DEPTH and read_data=0; read_data rises the cycle after a word completes.
- Assert reset mid-word (after segment 5) with 1 word buffered -> outputs clear immediately. After release the next accepted word starts at segment 0 with level=1.
